// File: rtl/sym_tally.sv
// Symbol tally for the symbol-counting game: latches symbols for display, counts specials
// and presses, scores presses against a reaction window and publishes the round result.
module sym_tally #(
    parameter int unsigned WINDOW    = 50_000_000,
    parameter int unsigned CNT_W     = 8,
    parameter logic [7:0]  BLANK_SYM = 8'hFF
) (
    input  logic             Clk100M,
    input  logic             Rst,
    input  logic             genSym,
    input  logic             generated,
    input  logic             special,
    input  logic [7:0]       generatedSym,
    input  logic             btnPress,
    output logic [7:0]       dispSym,
    output logic [CNT_W-1:0] specialCnt,
    output logic [CNT_W-1:0] pressCnt,
    output logic [CNT_W-1:0] hitCnt,
    output logic [CNT_W-1:0] falseCnt,
    output logic             roundDone,
    output logic             win
);

    localparam int unsigned      TMR_W    = $clog2(WINDOW + 1);
    localparam logic [TMR_W-1:0] WIN_LOAD = TMR_W'(WINDOW);

    typedef enum logic [1:0] {
        IDLE,
        PLAY,
        SCORE,
        DONE
    } state_e;

    state_e             state_q, state_d;
    logic               gen_prev_q;
    logic               gen_rise;
    logic [7:0]         disp_q, disp_d;
    logic [CNT_W-1:0]   special_q, special_d;
    logic [CNT_W-1:0]   press_q, press_d;
    logic [CNT_W-1:0]   hit_q, hit_d;
    logic [CNT_W-1:0]   false_q, false_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic               round_done_q, round_done_d;
    logic               win_q, win_d;
    logic               win_open;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign gen_rise = genSym && !gen_prev_q;
    // The window is open exactly while the countdown is non-zero.
    assign win_open = (timer_q != '0);

    // NOTE: every variable assigned in always_comb gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d      = state_q;
        disp_d       = disp_q;
        special_d    = special_q;
        press_d      = press_q;
        hit_d        = hit_q;
        false_d      = false_q;
        timer_d      = timer_q;
        round_done_d = round_done_q;
        win_d        = win_q;

        unique case (state_q)
            IDLE, DONE: begin
                if (state_q == DONE) begin
                    timer_d = '0;
                end
                if (gen_rise) begin
                    state_d      = PLAY;
                    disp_d       = BLANK_SYM;
                    special_d    = '0;
                    press_d      = '0;
                    hit_d        = '0;
                    false_d      = '0;
                    timer_d      = '0;
                    round_done_d = 1'b0;
                    win_d        = 1'b0;
                end
            end

            PLAY: begin
                if (!genSym) begin
                    state_d = SCORE;
                    timer_d = '0;
                end else begin
                    // Presses are judged against the window as it stood before this cycle.
                    if (btnPress) begin
                        press_d = sat_inc(press_q);
                        if (win_open) begin
                            hit_d   = sat_inc(hit_q);
                            timer_d = '0;
                        end else begin
                            false_d = sat_inc(false_q);
                        end
                    end else if (win_open) begin
                        timer_d = timer_q - TMR_W'(1);
                    end

                    if (generated) begin
                        disp_d = generatedSym;
                        if (special) begin
                            special_d = sat_inc(special_q);
                            timer_d   = WIN_LOAD;
                        end
                    end
                end
            end

            SCORE: begin
                state_d      = DONE;
                round_done_d = 1'b1;
                win_d        = (hit_q == special_q) && (false_q == '0);
            end

            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge Clk100M) begin
        if (Rst) begin
            state_q      <= IDLE;
            gen_prev_q   <= 1'b1;  // genSym already high out of reset is not a rising edge
            disp_q       <= BLANK_SYM;
            special_q    <= '0;
            press_q      <= '0;
            hit_q        <= '0;
            false_q      <= '0;
            timer_q      <= '0;
            round_done_q <= 1'b0;
            win_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            gen_prev_q   <= genSym;
            disp_q       <= disp_d;
            special_q    <= special_d;
            press_q      <= press_d;
            hit_q        <= hit_d;
            false_q      <= false_d;
            timer_q      <= timer_d;
            round_done_q <= round_done_d;
            win_q        <= win_d;
        end
    end

    assign dispSym    = disp_q;
    assign specialCnt = special_q;
    assign pressCnt   = press_q;
    assign hitCnt     = hit_q;
    assign falseCnt   = false_q;
    assign roundDone  = round_done_q;
    assign win        = win_q;

endmodule
